mrd_rdx5_feed: RTL and testbench

MRD_RDX5_FEED -- requirements
Module: mrd_rdx5_feed

---
 rtl/mrd_rdx5_feed_if.sv | 22 ++
 rtl/mrd_rdx5_feed.sv | 80 ++++++++
 tb/tb_mrd_rdx5_feed.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mrd_rdx5_feed_if.sv
// mrd_rdx5_feed_if: serial sample input and parallel 5-point group output of the radix-5 feeder
interface mrd_rdx5_feed_if;
  logic in_val;
  logic in_sop;
  logic signed [17:0] din_real;
  logic signed [17:0] din_imag;
  logic [3:0] exp_in;
  logic out_val;
  logic signed [17:0] dout_real [0:4];
  logic signed [17:0] dout_imag [0:4];
  logic [1:0] margin_out;
  logic [3:0] exp_out;
  logic seq_err;
  modport master (
    output in_val, in_sop, din_real, din_imag, exp_in,
    input out_val, dout_real, dout_imag, margin_out, exp_out, seq_err
  );
  modport slave (
    input in_val, in_sop, din_real, din_imag, exp_in,
    output out_val, dout_real, dout_imag, margin_out, exp_out, seq_err
  );
endinterface

// File: rtl/mrd_rdx5_feed.sv
// mrd_rdx5_feed: collects 5 serial complex samples into one parallel group with block exponent and headroom
module mrd_rdx5_feed #(
  parameter int MAX_MARGIN = 3
) (
  input logic clk,
  input logic rst_n,
  mrd_rdx5_feed_if.slave bus
);
  localparam logic [1:0] CAP = 2'(MAX_MARGIN);
  function automatic logic [1:0] headroom(input logic [17:0] v);
    logic [1:0] r;
    r = v[16] != v[17] ? 2'd0 : v[15] != v[17] ? 2'd1 : v[14] != v[17] ? 2'd2 : 2'd3;
    return r > CAP ? CAP : r;
  endfunction
  logic [2:0] idx_q, idx_d, slot;
  logic [1:0] min_q, min_d, m_re, m_im, m_in, grp_min;
  logic sop, last;
  logic [3:0] exp_q, exp_out_q;
  logic signed [17:0] re_q [0:3];
  logic signed [17:0] im_q [0:3];
  logic signed [17:0] dout_re_q [0:4];
  logic signed [17:0] dout_im_q [0:4];
  logic [1:0] margin_q;
  logic out_val_q, seq_err_q;
  always_comb begin
    sop = bus.in_val && bus.in_sop;
    slot = sop ? 3'd0 : idx_q;
    last = bus.in_val && slot == 3'd4;
    idx_d = sop ? 3'd1 : idx_q == 3'd4 ? 3'd0 : idx_q + 3'd1;
    m_re = headroom(bus.din_real);
    m_im = headroom(bus.din_imag);
    m_in = m_re < m_im ? m_re : m_im;
    grp_min = min_q < m_in ? min_q : m_in;
    min_d = slot == 3'd0 ? m_in : grp_min;
  end
  // slot 4 never lands in re_q/im_q: it goes straight into the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      min_q <= CAP;
      exp_q <= '0;
      exp_out_q <= '0;
      margin_q <= '0;
      out_val_q <= 1'b0;
      seq_err_q <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        re_q[k] <= '0;
        im_q[k] <= '0;
      end
      for (int k = 0; k < 5; k++) begin
        dout_re_q[k] <= '0;
        dout_im_q[k] <= '0;
      end
    end else begin
      out_val_q <= last;
      seq_err_q <= sop && idx_q != 3'd0;
      if (bus.in_val) begin
        idx_q <= idx_d;
        min_q <= min_d;
        if (slot == 3'd0) exp_q <= bus.exp_in;
        if (!last) begin
          re_q[slot[1:0]] <= bus.din_real;
          im_q[slot[1:0]] <= bus.din_imag;
        end
      end
      if (last) begin
        dout_re_q <= '{re_q[0], re_q[1], re_q[2], re_q[3], bus.din_real};
        dout_im_q <= '{im_q[0], im_q[1], im_q[2], im_q[3], bus.din_imag};
        margin_q <= grp_min;
        exp_out_q <= exp_q;
      end
    end
  end
  assign bus.out_val = out_val_q;
  assign bus.seq_err = seq_err_q;
  assign bus.margin_out = margin_q;
  assign bus.exp_out = exp_out_q;
  assign bus.dout_real = dout_re_q;
  assign bus.dout_imag = dout_im_q;
endmodule

// File: tb/tb_mrd_rdx5_feed.sv
// tb_mrd_rdx5_feed: directed vectors with hand-computed expectations for the radix-5 feeder
module tb_mrd_rdx5_feed;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  logic signed [17:0] er [0:4];
  logic signed [17:0] ei [0:4];
  mrd_rdx5_feed_if bif ();
  mrd_rdx5_feed #(.MAX_MARGIN(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic v, input logic s, input logic signed [17:0] re,
                      input logic signed [17:0] im, input logic [3:0] e);
    bif.in_val = v;
    bif.in_sop = s;
    bif.din_real = re;
    bif.din_imag = im;
    bif.exp_in = e;
    @(posedge clk);
    #1;
    bif.in_val = 1'b0;
    bif.in_sop = 1'b0;
  endtask
  task automatic idle();
    step(1'b0, 1'b1, 18'sh1FFFF, 18'sh1FFFF, 4'hF);
  endtask
  task automatic chk_dout(input string tag);
    for (int k = 0; k < 5; k++) begin
      chk({tag, "_re"}, 32'(bif.dout_real[k]), 32'(er[k]));
      chk({tag, "_im"}, 32'(bif.dout_imag[k]), 32'(ei[k]));
    end
  endtask
  task automatic mgrp(input string tag, input logic signed [17:0] sp, input int pos, input logic [1:0] em);
    for (int k = 0; k < 5; k++) step(1'b1, k == 0, k == pos ? sp : 18'sh3F000, 18'sh0, 4'h1);
    chk({tag, "_val"}, 32'(bif.out_val), 32'd1);
    chk({tag, "_margin"}, 32'(bif.margin_out), 32'(em));
  endtask
  initial begin
    bif.in_val = 1'b0;
    bif.in_sop = 1'b0;
    bif.din_real = '0;
    bif.din_imag = '0;
    bif.exp_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_val", 32'(bif.out_val), 32'd0);
    chk("rst_err", 32'(bif.seq_err), 32'd0);
    chk("rst_margin", 32'(bif.margin_out), 32'd0);
    chk("rst_exp", 32'(bif.exp_out), 32'd0);
    for (int k = 0; k < 5; k++) begin er[k] = '0; ei[k] = '0; end
    chk_dout("rst_dout");
    rst_n = 1'b1;
    idle();
    for (int k = 0; k < 5; k++) begin
      er[k] = 18'(k + 1);
      ei[k] = '0;
      step(1'b1, k == 0, er[k], 18'sh0, 4'd7);
      if (k < 4) chk("basic_early_val", 32'(bif.out_val), 32'd0);
    end
    chk("basic_val", 32'(bif.out_val), 32'd1);
    chk_dout("basic_dout");
    chk("basic_exp", 32'(bif.exp_out), 32'd7);
    chk("basic_margin", 32'(bif.margin_out), 32'd3);
    idle();
    chk("basic_strobe_end", 32'(bif.out_val), 32'd0);
    chk_dout("basic_hold");
    mgrp("m_10000", 18'sh10000, 4, 2'd0);
    mgrp("m_04000", 18'sh04000, 0, 2'd2);
    mgrp("m_38000", 18'sh38000, 2, 2'd2);
    mgrp("m_3F000", 18'sh3F000, 0, 2'd3);
    for (int k = 0; k < 3; k++) step(1'b1, k == 0, 18'sh100, 18'sh200, 4'd9);
    er[0] = 18'sh00031; ei[0] = -18'sd7;
    step(1'b1, 1'b1, er[0], ei[0], 4'd5);
    chk("resync_err", 32'(bif.seq_err), 32'd1);
    chk("resync_noval", 32'(bif.out_val), 32'd0);
    for (int k = 1; k < 5; k++) begin
      er[k] = 18'(16'h30 + k);
      ei[k] = -18'sd7 - 18'(k);
      step(1'b1, 1'b0, er[k], ei[k], 4'd0);
      if (k == 1) chk("resync_err_end", 32'(bif.seq_err), 32'd0);
      if (k < 4) chk("resync_early_val", 32'(bif.out_val), 32'd0);
    end
    chk("resync_val", 32'(bif.out_val), 32'd1);
    chk_dout("resync_dout");
    chk("resync_exp", 32'(bif.exp_out), 32'd5);
    for (int k = 0; k < 5; k++) begin
      er[k] = 18'(11 + k);
      ei[k] = -18'sd1 - 18'(k);
      step(1'b1, k == 0, er[k], ei[k], 4'hA);
      if (k < 4) begin
        chk("gap_early_val", 32'(bif.out_val), 32'd0);
        for (int g = 0; g < k; g++) begin
          idle();
          chk("gap_idle_val", 32'(bif.out_val), 32'd0);
        end
      end
    end
    chk("gap_val", 32'(bif.out_val), 32'd1);
    chk_dout("gap_dout");
    chk("gap_exp", 32'(bif.exp_out), 32'hA);
    repeat (3) idle();
    chk("gap_after_val", 32'(bif.out_val), 32'd0);
    chk_dout("gap_hold");
    for (int i = 0; i < 20; i++) begin
      int g, k;
      logic signed [17:0] v;
      logic [1:0] em;
      g = i / 5;
      k = i % 5;
      v = 18'(g * 10 + k + 1);
      if (g == 0 && k == 2) v = 18'sh10000;
      if (g == 2 && k == 0) v = 18'sh04000;
      er[k] = v;
      ei[k] = '0;
      step(1'b1, k == 0, v, 18'sh0, 4'(g));
      chk("strm_val", 32'(bif.out_val), 32'(k == 4));
      if (k == 4) begin
        em = g == 0 ? 2'd0 : g == 2 ? 2'd2 : 2'd3;
        chk("strm_margin", 32'(bif.margin_out), 32'(em));
        chk("strm_exp", 32'(bif.exp_out), 32'(g));
        chk_dout("strm_dout");
      end
    end
    step(1'b1, 1'b1, 18'sh777, 18'sh1, 4'd8);
    step(1'b1, 1'b0, 18'sh778, 18'sh2, 4'd8);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin er[k] = '0; ei[k] = '0; end
    chk("mid_rst_val", 32'(bif.out_val), 32'd0);
    chk("mid_rst_margin", 32'(bif.margin_out), 32'd0);
    chk("mid_rst_exp", 32'(bif.exp_out), 32'd0);
    chk_dout("mid_rst_dout");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      er[k] = 18'(21 + k);
      ei[k] = 18'(k);
      step(1'b1, 1'b0, er[k], ei[k], k == 0 ? 4'd3 : 4'd12);
      if (k < 4) chk("post_rst_early_val", 32'(bif.out_val), 32'd0);
    end
    chk("post_rst_val", 32'(bif.out_val), 32'd1);
    chk("post_rst_err", 32'(bif.seq_err), 32'd0);
    chk_dout("post_rst_dout");
    chk("post_rst_exp", 32'(bif.exp_out), 32'd3);
    chk("post_rst_margin", 32'(bif.margin_out), 32'd3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
